// File: rtl/cpu_defs.sv
// Shared types and constants for the CPU memory-side blocks.
package cpu_defs;

    localparam int CPU_ADDR_W       = 32;
    localparam int CPU_DATA_W       = 32;
    localparam int INST_FETCH_BEATS = 2;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        INST1,
        INST2,
        RESP
    } ArbState_t;

    // Captured request; drives the downstream port for the whole transaction.
    typedef struct packed {
        logic                  we;
        logic [3:0]            be;
        logic [CPU_ADDR_W-1:0] addr;
        logic [CPU_DATA_W-1:0] wdata;
    } MemReq_t;

endpackage

// File: rtl/arb_pick.sv
// Fixed-priority pick: data wins unless instruction fetch is being starved.
module arb_pick (
    input  logic inst_req,
    input  logic data_req,
    input  logic starve,
    output logic grant_inst,
    output logic grant_data
);

    assign grant_data = data_req & ~(inst_req & starve);
    assign grant_inst = inst_req & (~data_req | starve);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between a two-word instruction fetch and a data port,
// data-first with an anti-starvation streak counter for fetch.
module mem_bus_arbiter
    import cpu_defs::*;
#(
    parameter int ADDR_WIDTH   = CPU_ADDR_W,
    parameter int DATA_WIDTH   = CPU_DATA_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inst_req,
    input  logic [ADDR_WIDTH-1:0] inst_addr,
    output logic                  inst_ack,
    output logic [DATA_WIDTH-1:0] inst_rdata,
    output logic [DATA_WIDTH-1:0] inst_rdata_2,
    input  logic                  data_req,
    input  logic                  data_we,
    input  logic [3:0]            data_be,
    input  logic [ADDR_WIDTH-1:0] data_addr,
    input  logic [DATA_WIDTH-1:0] data_wdata,
    output logic                  data_ack,
    output logic [DATA_WIDTH-1:0] data_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [3:0]            mem_be,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int SW       = $clog2(STARVE_LIMIT + 1);
    localparam int BEAT_OFS = (INST_FETCH_BEATS - 1) * (DATA_WIDTH / 8);

    ArbState_t             state_q, state_d;
    MemReq_t               req_q, req_d;
    logic [SW-1:0]         streak_q, streak_d;
    logic                  mem_req_q, mem_req_d;
    logic                  inst_ack_q, inst_ack_d;
    logic                  data_ack_q, data_ack_d;
    logic [DATA_WIDTH-1:0] inst_rdata_q, inst_rdata_d;
    logic [DATA_WIDTH-1:0] inst_rdata_2_q, inst_rdata_2_d;
    logic [DATA_WIDTH-1:0] data_rdata_q, data_rdata_d;

    logic starve, grant_inst, grant_data;

    assign starve = (streak_q == SW'(STARVE_LIMIT));

    arb_pick u_pick (
        .inst_req   (inst_req),
        .data_req   (data_req),
        .starve     (starve),
        .grant_inst (grant_inst),
        .grant_data (grant_data)
    );

    always_comb begin
        state_d        = state_q;
        req_d          = req_q;
        streak_d       = streak_q;
        mem_req_d      = mem_req_q;
        inst_ack_d     = 1'b0;
        data_ack_d     = 1'b0;
        inst_rdata_d   = inst_rdata_q;
        inst_rdata_2_d = inst_rdata_2_q;
        data_rdata_d   = data_rdata_q;
        case (state_q)
            IDLE: begin
                if (grant_data) begin
                    req_d     = '{we: data_we, be: data_be, addr: data_addr, wdata: data_wdata};
                    mem_req_d = 1'b1;
                    state_d   = DATA;
                    if (inst_req && !starve) streak_d = streak_q + SW'(1);
                end else if (grant_inst) begin
                    req_d     = '{we: 1'b0, be: 4'hF, addr: inst_addr, wdata: '0};
                    mem_req_d = 1'b1;
                    streak_d  = '0;
                    state_d   = INST1;
                end
            end
            DATA: if (mem_ack) begin
                data_rdata_d = mem_rdata;
                data_ack_d   = 1'b1;
                mem_req_d    = 1'b0;
                state_d      = RESP;
            end
            // mem_req stays high across the beat boundary; only the address moves.
            INST1: if (mem_ack) begin
                inst_rdata_d = mem_rdata;
                req_d.addr   = req_q.addr + ADDR_WIDTH'(BEAT_OFS);
                state_d      = INST2;
            end
            INST2: if (mem_ack) begin
                inst_rdata_2_d = mem_rdata;
                inst_ack_d     = 1'b1;
                mem_req_d      = 1'b0;
                state_d        = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            req_q          <= '0;
            streak_q       <= '0;
            mem_req_q      <= 1'b0;
            inst_ack_q     <= 1'b0;
            data_ack_q     <= 1'b0;
            inst_rdata_q   <= '0;
            inst_rdata_2_q <= '0;
            data_rdata_q   <= '0;
        end else begin
            state_q        <= state_d;
            req_q          <= req_d;
            streak_q       <= streak_d;
            mem_req_q      <= mem_req_d;
            inst_ack_q     <= inst_ack_d;
            data_ack_q     <= data_ack_d;
            inst_rdata_q   <= inst_rdata_d;
            inst_rdata_2_q <= inst_rdata_2_d;
            data_rdata_q   <= data_rdata_d;
        end
    end

    assign inst_ack     = inst_ack_q;
    assign inst_rdata   = inst_rdata_q;
    assign inst_rdata_2 = inst_rdata_2_q;
    assign data_ack     = data_ack_q;
    assign data_rdata   = data_rdata_q;
    assign mem_req      = mem_req_q;
    assign mem_we       = req_q.we;
    assign mem_be       = req_q.be;
    assign mem_addr     = req_q.addr;
    assign mem_wdata    = req_q.wdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: data/fetch paths, starvation order,
// wait states, async reset mid-fetch and address wrap.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_req = 1'b0;
    logic [31:0] inst_addr = '0;
    logic        inst_ack;
    logic [31:0] inst_rdata, inst_rdata_2;
    logic        data_req = 1'b0;
    logic        data_we = 1'b0;
    logic [3:0]  data_be = '0;
    logic [31:0] data_addr = '0;
    logic [31:0] data_wdata = '0;
    logic        data_ack;
    logic [31:0] data_rdata;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    logic auto_ack  = 1'b0;
    logic force_ack = 1'b0;

    int n_tot  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    // Memory model: zero-wait ack when auto_ack, otherwise manual pulses.
    assign mem_ack = (auto_ack & mem_req) | force_ack;

    always_comb begin
        case (mem_addr)
            32'hBFC0_0000: mem_rdata = 32'h1111_1111;
            32'hBFC0_0004: mem_rdata = 32'h2222_2222;
            32'hFFFF_FFFC: mem_rdata = 32'hA5A5_A5A5;
            32'h0000_0000: mem_rdata = 32'h5A5A_5A5A;
            32'h0000_2000: mem_rdata = 32'hCAFE_F00D;
            default:       mem_rdata = ~mem_addr;
        endcase
    end

    mem_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_ack     (inst_ack),
        .inst_rdata   (inst_rdata),
        .inst_rdata_2 (inst_rdata_2),
        .data_req     (data_req),
        .data_we      (data_we),
        .data_be      (data_be),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_ack     (data_ack),
        .data_rdata   (data_rdata),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_be       (mem_be),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int   g;
        logic prev;
        logic [9:0] exp_inst;

        // Reset state
        #12;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_acks", {inst_ack, data_ack}, 0);
        chk("rst_rdata", {inst_rdata, data_rdata}, 0);
        rst = 1'b0;
        tick();

        // 1: data write, zero-wait
        auto_ack = 1'b1;
        data_req = 1'b1; data_we = 1'b1; data_be = 4'hF;
        data_addr = 32'h1000; data_wdata = 32'hDEAD_BEEF;
        tick();
        chk("t1_c1_req_we", {mem_req, mem_we}, 2'b11);
        chk("t1_c1_addr", mem_addr, 32'h1000);
        chk("t1_c1_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("t1_c1_be", mem_be, 4'hF);
        chk("t1_c1_noack", {inst_ack, data_ack}, 0);
        tick();
        chk("t1_c2_data_ack", data_ack, 1);
        chk("t1_c2_no_inst_ack", inst_ack, 0);
        chk("t1_c2_mem_req", mem_req, 0);
        tick();
        data_req = 1'b0; data_we = 1'b0;
        chk("t1_c3_ack_gone", data_ack, 0);
        tick();

        // 2: fetch at 0xBFC0_0000
        inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
        tick();
        chk("t2_c1_req", {mem_req, mem_we, mem_be}, 6'b10_1111);
        chk("t2_c1_addr", mem_addr, 32'hBFC0_0000);
        tick();
        chk("t2_c2_req", mem_req, 1);
        chk("t2_c2_addr", mem_addr, 32'hBFC0_0004);
        chk("t2_c2_noack", inst_ack, 0);
        tick();
        chk("t2_c3_inst_ack", inst_ack, 1);
        chk("t2_c3_no_data_ack", data_ack, 0);
        chk("t2_c3_rdata", inst_rdata, 32'h1111_1111);
        chk("t2_c3_rdata_2", inst_rdata_2, 32'h2222_2222);
        tick();
        inst_req = 1'b0;
        tick();

        // 3: both requesters always on; expect D,D,D,D,I,D,D,D,D,I
        data_req = 1'b1; data_we = 1'b0; data_be = 4'hF; data_addr = 32'h3000;
        inst_req = 1'b1; inst_addr = 32'h4000;
        exp_inst = 10'b10_0001_0000;
        g = 0;
        for (int c = 0; c < 100 && g < 10; c++) begin
            prev = mem_req;
            tick();
            if (mem_req && !prev) begin
                chk($sformatf("t3_grant%0d_is_inst", g), (mem_addr == 32'h4000), exp_inst[g]);
                g++;
            end
        end
        chk("t3_grant_count", g, 10);
        data_req = 1'b0; inst_req = 1'b0;
        repeat (6) tick();

        // 4: data read at 0x2000 with 3 wait states
        auto_ack = 1'b0;
        data_req = 1'b1; data_we = 1'b0; data_be = 4'h3; data_addr = 32'h2000;
        tick();
        chk("t4_c1", {mem_req, mem_we, mem_be, mem_addr}, {1'b1, 1'b0, 4'h3, 32'h2000});
        data_addr = 32'h9999_0000; data_be = 4'hC;
        tick();
        chk("t4_c2_stable", {mem_req, mem_we, mem_be, mem_addr}, {1'b1, 1'b0, 4'h3, 32'h2000});
        tick();
        chk("t4_c3_stable", {mem_req, mem_be, mem_addr, data_ack}, {1'b1, 4'h3, 32'h2000, 1'b0});
        tick();
        chk("t4_c4_stable", {mem_req, mem_be, mem_addr, data_ack}, {1'b1, 4'h3, 32'h2000, 1'b0});
        force_ack = 1'b1;
        tick();
        force_ack = 1'b0;
        chk("t4_c5_ack", {data_ack, mem_req}, 2'b10);
        chk("t4_c5_rdata", data_rdata, 32'hCAFE_F00D);
        tick();
        data_req = 1'b0;
        chk("t4_c6_single_ack", data_ack, 0);
        chk("t4_rdata_hold", data_rdata, 32'hCAFE_F00D);
        tick();

        // 5: reset while in INST2
        inst_req = 1'b1; inst_addr = 32'h8000;
        tick();
        force_ack = 1'b1;
        tick();
        force_ack = 1'b0;
        chk("t5_in_inst2", {mem_req, mem_addr}, {1'b1, 32'h8004});
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_mem", {mem_req, mem_we, mem_be, mem_addr, mem_wdata}, 0);
        chk("t5_rst_out", {inst_ack, data_ack, inst_rdata, inst_rdata_2, data_rdata}, 0);
        inst_req = 1'b0;
        #2 rst = 1'b0;
        tick();
        auto_ack = 1'b1;
        inst_req = 1'b1; inst_addr = 32'h0;
        tick();
        chk("t5_fresh_c1", {mem_req, mem_addr}, {1'b1, 32'h0});
        tick();
        chk("t5_fresh_c2", {mem_req, mem_addr}, {1'b1, 32'h4});
        tick();
        chk("t5_fresh_ack", {inst_ack, inst_rdata, inst_rdata_2},
            {1'b1, 32'h5A5A_5A5A, 32'hFFFF_FFFB});
        tick();
        inst_req = 1'b0;
        tick();

        // 6: fetch wrap and spurious ack in IDLE
        inst_req = 1'b1; inst_addr = 32'hFFFF_FFFC;
        tick();
        chk("t6_c1_addr", mem_addr, 32'hFFFF_FFFC);
        tick();
        chk("t6_c2_wrap", {mem_req, mem_addr}, {1'b1, 32'h0});
        tick();
        chk("t6_c3_ack", {inst_ack, inst_rdata, inst_rdata_2},
            {1'b1, 32'hA5A5_A5A5, 32'h5A5A_5A5A});
        tick();
        inst_req = 1'b0;
        auto_ack = 1'b0;
        tick();
        force_ack = 1'b1;
        tick();
        tick();
        force_ack = 1'b0;
        chk("t6_spurious_noack", {inst_ack, data_ack, mem_req}, 0);
        tick();
        chk("t6_spurious_quiet", {inst_ack, data_ack, mem_req}, 0);
        chk("t6_rdata_hold", {inst_rdata, data_rdata}, {32'hA5A5_A5A5, 32'h0});

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one physical memory port between the instruction fetch requester (IF, read-only, two-word fetch) and the data requester (MEM, read/write, single word).
- Sits between the CPU core's fetch/data request paths and the single bus master port to the memory system.
- Serialises transactions with a locked grant.
- Gives data priority, bounded by an anti-starvation counter for instruction fetch.

Parameters:
ADDR_WIDTH, 32, byte address width.
DATA_WIDTH, 32, word width.
STARVE_LIMIT, 4, max consecutive data grants while an inst request waits; must be >= 1.

Ports:
clk  in  1  clock.
rst  in  1  asynchronous, active-high reset.
inst_req  in  1  fetch request; level, held until inst_ack.
inst_addr  in  ADDR_WIDTH  fetch address, word aligned.
inst_ack  out  1  one-cycle pulse: fetch complete.
inst_rdata  out  DATA_WIDTH  word at inst_addr; valid with inst_ack.
inst_rdata_2  out  DATA_WIDTH  word at inst_addr+4; valid with inst_ack.
data_req  in  1  data request; level, held until data_ack.
data_we  in  1  1 = write.
data_be  in  4  byte enables.
data_addr  in  ADDR_WIDTH  data address.
data_wdata  in  DATA_WIDTH  write data.
data_ack  out  1  one-cycle pulse: data access complete.
data_rdata  out  DATA_WIDTH  read data; valid with data_ack.
mem_req  out  1  downstream request; held until mem_ack.
mem_we  out  1  downstream write.
mem_be  out  4  downstream byte enables.
mem_addr  out  ADDR_WIDTH  downstream address.
mem_wdata  out  DATA_WIDTH  downstream write data.
mem_ack  in  1  downstream completion; may assert in the same cycle mem_req is first seen (zero wait).
mem_rdata  in  DATA_WIDTH  downstream read data; valid with mem_ack.

Behaviour:
- All outputs are registered.
- Reset values (asynchronous): every output 0; state IDLE; streak counter 0.
- States:
  - IDLE: sample requests and arbitrate.
  - DATA: data access on the downstream port.
  - INST1: fetch word at inst_addr.
  - INST2: fetch word at inst_addr+4.
  - RESP: assert exactly one of inst_ack / data_ack.
- Arbitration in IDLE:
  - Only data_req set -> DATA.
  - Only inst_req set -> INST1.
  - Both set -> DATA unless streak == STARVE_LIMIT, in which case INST1.
- Streak counter:
  - Increments on a data grant while inst_req is high.
  - Clears on every inst grant.
  - Saturates at STARVE_LIMIT.
- Request capture: on a grant, the requester's address, we, be and wdata are latched. Downstream fields come from the latch, so the requester changing fields mid-transaction has no effect.
- Downstream port during a transaction:
  - mem_req is 1 in every cycle of DATA/INST1/INST2 until the cycle mem_ack is seen; it is 0 in IDLE and RESP.
  - For fetches: mem_we = 0, mem_be = 4'hF.
- DATA + mem_ack: capture mem_rdata -> RESP (data_ack = 1 next cycle).
- INST1 + mem_ack: capture word 0. Next state INST2 with mem_addr = latched addr + 4 (mod 2^ADDR_WIDTH, wraps FFFF_FFFC -> 0000_0000); mem_req stays asserted continuously into INST2.
- INST2 + mem_ack: capture word 1 -> RESP (inst_ack = 1).
- RESP -> IDLE unconditionally. The requester drops its req the cycle after the ack, so the request is never double-granted.
- Minimum latency with zero-wait memory, req visible at cycle 0:
  - Data: mem_req at cycle 1, data_ack at cycle 2.
  - Fetch: beats at cycles 1 and 2, inst_ack at cycle 3.
- mem_ack in IDLE or RESP is ignored.
- inst_rdata* and data_rdata hold their last values outside ack cycles.
- Reset mid-transaction: immediate return to IDLE, mem_req = 0, no ack issued. The downstream must tolerate the abandoned request.
- A requester deasserting req before its ack is illegal; the transaction completes anyway and the ack is still pulsed.

Decomposition:
- Shared package cpu_defs gets:
  - ArbState_t enum (IDLE, DATA, INST1, INST2, RESP).
  - MemReq_t struct (we, be, addr, wdata) for the capture latch.
  - Constant INST_FETCH_BEATS = 2.
- One combinational sub-module, arb_pick: inputs inst_req, data_req, starve; outputs grant_inst, grant_data.

Test Plan:
1. Data write only (addr 0x1000, wdata 0xDEADBEEF, be 4'hF), zero-wait memory -> mem_req/mem_we = 1 at cycle 1 with matching fields; data_ack at cycle 2; no inst_ack.
2. Fetch at 0xBFC0_0000, memory returns 0x11111111 then 0x22222222 -> mem_addr 0xBFC00000 then 0xBFC00004; inst_ack at cycle 3 with inst_rdata = 0x11111111, inst_rdata_2 = 0x22222222.
3. Both requests every cycle, STARVE_LIMIT = 4 -> grant order is D,D,D,D,I,D,D,D,D,I; the streak counter never exceeds 4.
4. Memory inserts 3 wait states per beat on a data read of 0x2000 -> mem_req held for 4 cycles with stable fields; data_ack exactly once, carrying the acked mem_rdata.
5. Reset asserted while in INST2 -> all outputs 0 asynchronously; after release, a fresh inst_req at 0x0 starts at INST1 with mem_addr = 0x0.
6. Fetch at 0xFFFF_FFFC -> second beat mem_addr = 0x0000_0000; a spurious mem_ack in IDLE produces no ack output.
